// File: rtl/phy_pkg.sv
// Shared PHY receive-path definitions: default alignment symbols and the
// encoding of the alignment FSM states.
package phy_pkg;

   localparam logic [7:0] COMMA_DEF = 8'hBC;
   localparam logic [7:0] IDLE_DEF  = 8'h7C;

   typedef logic [1:0] state_t;

   localparam state_t HUNT   = 2'd0;
   localparam state_t CHECK  = 2'd1;
   localparam state_t LOCKED = 2'd2;

endpackage

// File: rtl/detector_coma.sv
// Serial input shift register with comparators against the comma and idle
// symbols; the comparisons always reflect the current register contents.
module detector_coma
   import phy_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] COMMA = COMMA_DEF,
   parameter logic [WIDTH-1:0] IDLE  = IDLE_DEF
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_paralelo_serial,
   output logic [WIDTH-1:0] sr,
   output logic             is_comma,
   output logic             is_idle
);

   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         sr <= '0;
      end else begin
         sr <= {sr[WIDTH-2:0], data_paralelo_serial};
      end
   end

   assign is_comma = (sr == COMMA);
   assign is_idle  = (sr == IDLE);

endmodule

// File: rtl/serial_paralelo_alineado.sv
// Comma-aligned serial-to-parallel deserializer: hunts for a comma at any bit
// offset, locks after a run of aligned commas and strips comma/idle words.
module serial_paralelo_alineado
   import phy_pkg::*;
#(
   parameter int unsigned      WIDTH        = 8,
   parameter logic [WIDTH-1:0] COMMA        = COMMA_DEF,
   parameter logic [WIDTH-1:0] IDLE         = IDLE_DEF,
   parameter int unsigned      LOCK_COMMAS  = 4,
   parameter int unsigned      MISALIGN_MAX = 3
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_paralelo_serial,
   output logic             active_serial_paralelo,
   output logic             valid_serial_paralelo,
   output logic [WIDTH-1:0] data_serial_paralelo,
   output logic             realign_serial_paralelo
);

   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(LOCK_COMMAS + 1);
   localparam int unsigned MW = $clog2(MISALIGN_MAX + 1);

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] LOCK_N   = CW'(LOCK_COMMAS);
   localparam logic [MW-1:0] MIS_N    = MW'(MISALIGN_MAX);

   if (WIDTH < 4) begin : g_chk_width
      $error("WIDTH must be at least 4");
   end
   if (COMMA == IDLE) begin : g_chk_symbols
      $error("COMMA and IDLE must differ");
   end
   if (LOCK_COMMAS < 1 || MISALIGN_MAX < 1) begin : g_chk_counts
      $error("LOCK_COMMAS and MISALIGN_MAX must be at least 1");
   end

   logic [WIDTH-1:0] sr;
   logic             is_comma;
   logic             is_idle;

   state_t           state;
   logic [BW-1:0]    bit_cnt;
   logic [CW-1:0]    comma_cnt;
   logic [MW-1:0]    misalign_cnt;
   logic             boundary;

   detector_coma #(
      .WIDTH (WIDTH),
      .COMMA (COMMA),
      .IDLE  (IDLE)
   ) u_detector_coma (
      .clk_32f              (clk_32f),
      .reset                (reset),
      .data_paralelo_serial (data_paralelo_serial),
      .sr                   (sr),
      .is_comma             (is_comma),
      .is_idle              (is_idle)
   );

   assign boundary               = (bit_cnt == BIT_LAST);
   assign active_serial_paralelo = (state == LOCKED);

   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         state                   <= HUNT;
         bit_cnt                 <= '0;
         comma_cnt               <= '0;
         misalign_cnt            <= '0;
         valid_serial_paralelo   <= 1'b0;
         data_serial_paralelo    <= '0;
         realign_serial_paralelo <= 1'b0;
      end else begin
         realign_serial_paralelo <= 1'b0;
         bit_cnt                 <= boundary ? '0 : bit_cnt + 1'b1;

         case (state)
            HUNT: begin
               // A comma seen here defines the word phase: the next edge
               // samples the first bit of the following word.
               if (is_comma) begin
                  bit_cnt   <= '0;
                  comma_cnt <= CW'(1);
                  state     <= (LOCK_COMMAS == 1) ? LOCKED : CHECK;
               end
            end

            CHECK: begin
               if (boundary) begin
                  if (is_comma) begin
                     comma_cnt <= comma_cnt + 1'b1;
                     if (comma_cnt + 1'b1 == LOCK_N) begin
                        state <= LOCKED;
                     end
                  end else begin
                     comma_cnt <= '0;
                     state     <= HUNT;
                  end
               end
            end

            LOCKED: begin
               if (boundary) begin
                  if (is_comma) begin
                     valid_serial_paralelo <= 1'b0;
                     misalign_cnt          <= '0;
                  end else if (is_idle) begin
                     valid_serial_paralelo <= 1'b0;
                  end else begin
                     data_serial_paralelo  <= sr;
                     valid_serial_paralelo <= 1'b1;
                  end
               end else if (is_comma) begin
                  // Loss of lock fires on the same edge that counts the
                  // last tolerated misaligned comma.
                  if (misalign_cnt + 1'b1 == MIS_N) begin
                     state                   <= HUNT;
                     realign_serial_paralelo <= 1'b1;
                     valid_serial_paralelo   <= 1'b0;
                     data_serial_paralelo    <= '0;
                     bit_cnt                 <= '0;
                     comma_cnt               <= '0;
                     misalign_cnt            <= '0;
                  end else begin
                     misalign_cnt <= misalign_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state <= HUNT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_paralelo_alineado.sv
// Directed bench for serial_paralelo_alineado with default parameters; every
// tick drives one serial bit and checks {active, valid, realign, data}.
module tb_serial_paralelo_alineado;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       din     = 1'b0;
   logic       active;
   logic       valid;
   logic       realign;
   logic [7:0] data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [7:0] w;
      logic       a;
      logic       v;
      logic [7:0] d;
   } row_t;

   serial_paralelo_alineado #(
      .WIDTH        (8),
      .COMMA        (8'hBC),
      .IDLE         (8'h7C),
      .LOCK_COMMAS  (4),
      .MISALIGN_MAX (3)
   ) dut (
      .clk_32f                 (clk_32f),
      .reset                   (reset),
      .data_paralelo_serial    (din),
      .active_serial_paralelo  (active),
      .valid_serial_paralelo   (valid),
      .data_serial_paralelo    (data),
      .realign_serial_paralelo (realign)
   );

   always #5 clk_32f = ~clk_32f;

   task automatic tick(input logic b);
      din = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1'($urandom_range(0, 1)));
         n_checks++;
         if ({active, valid, realign, data} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_hold c%0d: got a=%b v=%b r=%b d=%h, want all 0", i, active, valid, realign, data);
         end
      end
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         tick(1'b0);
         n_checks++;
         if ({active, valid, realign, data} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_nolock c%0d: got a=%b v=%b r=%b d=%h, want all 0", i, active, valid, realign, data);
         end
      end
   endtask

   task automatic test_arbitrary_lock();
      row_t rows [7] = '{
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'hBC, 1'b0, 1'b0, 8'h00},
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'hBC, 1'b0, 1'b0, 8'h00},
         '{8'hA5, 1'b1, 1'b0, 8'h00}, '{8'h3C, 1'b1, 1'b1, 8'hA5},
         '{8'h00, 1'b1, 1'b1, 8'h3C}};
      logic [2:0] junk = 3'b101;
      for (int i = 2; i >= 0; i--) begin
         tick(junk[i]);
         n_checks++;
         if ({active, valid, realign, data} !== 11'd0) begin
            n_fail++;
            $display("FAIL lock_junk b%0d: got a=%b v=%b r=%b d=%h, want all 0", i, active, valid, realign, data);
         end
      end
      foreach (rows[r]) begin
         for (int i = 7; i >= 0; i--) begin
            tick(rows[r].w[i]);
            n_checks++;
            if ({active, valid, realign, data} !== {rows[r].a, rows[r].v, 1'b0, rows[r].d}) begin
               n_fail++;
               $display("FAIL lock_offset r%0d b%0d: got a=%b v=%b r=%b d=%h, want a=%b v=%b r=0 d=%h",
                        r, i, active, valid, realign, data, rows[r].a, rows[r].v, rows[r].d);
            end
         end
      end
   endtask

   task automatic test_incomplete_lock();
      row_t rows [9] = '{
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'hBC, 1'b0, 1'b0, 8'h00},
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'h55, 1'b0, 1'b0, 8'h00},
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'hBC, 1'b0, 1'b0, 8'h00},
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'hBC, 1'b0, 1'b0, 8'h00},
         '{8'h66, 1'b1, 1'b0, 8'h00}};
      reset = 1'b0;
      tick(1'b0);
      tick(1'b0);
      reset = 1'b1;
      foreach (rows[r]) begin
         for (int i = 7; i >= 0; i--) begin
            tick(rows[r].w[i]);
            n_checks++;
            if ({active, valid, realign, data} !== {rows[r].a, rows[r].v, 1'b0, rows[r].d}) begin
               n_fail++;
               $display("FAIL incomplete_lock r%0d b%0d: got a=%b v=%b r=%b d=%h, want a=%b v=%b r=0 d=%h",
                        r, i, active, valid, realign, data, rows[r].a, rows[r].v, rows[r].d);
            end
         end
      end
   endtask

   task automatic test_stripping();
      row_t rows [5] = '{
         '{8'h11, 1'b1, 1'b1, 8'h66}, '{8'h7C, 1'b1, 1'b1, 8'h11},
         '{8'hBC, 1'b1, 1'b0, 8'h11}, '{8'h22, 1'b1, 1'b0, 8'h11},
         '{8'h00, 1'b1, 1'b1, 8'h22}};
      foreach (rows[r]) begin
         for (int i = 7; i >= 0; i--) begin
            tick(rows[r].w[i]);
            n_checks++;
            if ({active, valid, realign, data} !== {rows[r].a, rows[r].v, 1'b0, rows[r].d}) begin
               n_fail++;
               $display("FAIL stripping r%0d b%0d: got a=%b v=%b r=%b d=%h, want a=%b v=%b r=0 d=%h",
                        r, i, active, valid, realign, data, rows[r].a, rows[r].v, rows[r].d);
            end
         end
      end
   endtask

   task automatic test_bit_slip();
      logic [7:0]  comma = 8'hBC;
      logic [10:0] exp;
      row_t rows [2] = '{'{8'h5A, 1'b1, 1'b0, 8'h00}, '{8'h00, 1'b1, 1'b1, 8'h5A}};
      tick(1'b0);
      n_checks++;
      if ({active, valid, realign, data} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL slip_extra: got a=%b v=%b r=%b d=%h, want a=1 v=1 r=0 d=00", active, valid, realign, data);
      end
      // Words now straddle the old phase: 0x5E is captured until the third
      // misaligned comma (tick 25) drops lock; commas 4..7 relock.
      for (int k = 0; k < 7; k++) begin
         for (int i = 7; i >= 0; i--) begin
            int g;
            tick(comma[i]);
            g = 8 * k + (8 - i);
            if (g <= 7)       exp = {1'b1, 1'b1, 1'b0, 8'h00};
            else if (g <= 24) exp = {1'b1, 1'b1, 1'b0, 8'h5E};
            else if (g == 25) exp = {1'b0, 1'b0, 1'b1, 8'h00};
            else              exp = 11'd0;
            n_checks++;
            if ({active, valid, realign, data} !== exp) begin
               n_fail++;
               $display("FAIL bit_slip t%0d: got a=%b v=%b r=%b d=%h, want a=%b v=%b r=%b d=%h",
                        g, active, valid, realign, data, exp[10], exp[9], exp[8], exp[7:0]);
            end
         end
      end
      foreach (rows[r]) begin
         for (int i = 7; i >= 0; i--) begin
            tick(rows[r].w[i]);
            n_checks++;
            if ({active, valid, realign, data} !== {rows[r].a, rows[r].v, 1'b0, rows[r].d}) begin
               n_fail++;
               $display("FAIL slip_relock r%0d b%0d: got a=%b v=%b r=%b d=%h, want a=%b v=%b r=0 d=%h",
                        r, i, active, valid, realign, data, rows[r].a, rows[r].v, rows[r].d);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      row_t rows [10] = '{
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'hBC, 1'b0, 1'b0, 8'h00},
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'h77, 1'b0, 1'b0, 8'h00},
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'hBC, 1'b0, 1'b0, 8'h00},
         '{8'hBC, 1'b0, 1'b0, 8'h00}, '{8'hBC, 1'b0, 1'b0, 8'h00},
         '{8'h99, 1'b1, 1'b0, 8'h00}, '{8'h00, 1'b1, 1'b1, 8'h99}};
      reset = 1'b0;
      tick(1'b1);
      reset = 1'b1;
      n_checks++;
      if ({active, valid, realign, data} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got a=%b v=%b r=%b d=%h, want all 0", active, valid, realign, data);
      end
      foreach (rows[r]) begin
         for (int i = 7; i >= 0; i--) begin
            tick(rows[r].w[i]);
            n_checks++;
            if ({active, valid, realign, data} !== {rows[r].a, rows[r].v, 1'b0, rows[r].d}) begin
               n_fail++;
               $display("FAIL reset_relock r%0d b%0d: got a=%b v=%b r=%b d=%h, want a=%b v=%b r=0 d=%h",
                        r, i, active, valid, realign, data, rows[r].a, rows[r].v, rows[r].d);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_arbitrary_lock();
      test_incomplete_lock();
      test_stripping();
      test_bit_slip();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_paralelo_alineado.md
# serial_paralelo_alineado

Parametrised serial-to-parallel deserializer for the PHY receive path. It recovers word alignment from a comma symbol found at any bit offset, requires a run of commas before declaring lock, and strips comma/idle symbols from the output. It tracks misaligned commas and re-hunts after a bit slip. It sits after the serial line input and feeds the receive byte-stripping logic. Single clock domain, clk_32f, with one bit received per clock.

## Interface
Parameters:
- WIDTH, 8: word/symbol width in bits (≥4).
- COMMA, 8'hBC: alignment symbol (WIDTH bits).
- IDLE, 8'h7C: filler symbol, never output as data. Must differ from COMMA.
- LOCK_COMMAS, 4: consecutive aligned commas needed for lock (≥1).
- MISALIGN_MAX, 3: misaligned commas that force loss of lock (≥1).

Ports:
- clk_32f  in  1  bit clock; all logic on the rising edge.
- reset  in  1  reset reset, synchronous, active-low; clock clk_32f.
- data_paralelo_serial  in  1  serial bit, MSB of each word first.
- active_serial_paralelo  out  1  high while in LOCKED.
- valid_serial_paralelo  out  1  high for one word period per data word.
- data_serial_paralelo  out  WIDTH  last data word.
- realign_serial_paralelo  out  1  one-cycle pulse on loss of lock.

## Operation
- Shift register: sr <= {sr[WIDTH-2:0], data_paralelo_serial} every edge.
- bit_cnt: 0..WIDTH-1, wraps. A boundary edge is an edge where bit_cnt == WIDTH-1.
- HUNT (reset state):
  - Compare sr with COMMA on every edge.
  - On a match: bit_cnt <= 0, comma_cnt <= 1, go to CHECK. If LOCK_COMMAS == 1, go to LOCKED instead.
- CHECK, at boundary edges only:
  - If sr == COMMA: comma_cnt++. When comma_cnt reaches LOCK_COMMAS, go to LOCKED.
  - Otherwise: comma_cnt <= 0, go to HUNT. Searching restarts on the next edge.
- LOCKED, at boundary edges:
  - sr == COMMA: valid <= 0, misalign_cnt <= 0.
  - sr == IDLE: valid <= 0.
  - Any other value: data <= sr, valid <= 1.
- LOCKED, at non-boundary edges:
  - If sr == COMMA: misalign_cnt++ (saturating).
  - When misalign_cnt reaches MISALIGN_MAX: go to HUNT, pulse realign for one cycle, active <= 0, valid <= 0, data <= 0, all counters <= 0.
- Outputs:
  - active is 1 exactly while in LOCKED.
  - data holds its value across comma and idle words.
  - valid stays asserted across consecutive data words.

## Timing
- Reset (reset == 0 at an edge):
  - After that edge: all outputs 0, state HUNT, sr = 0, all counters 0.
  - Reset mid-word discards the partial word.
  - First bit sampled is the one at the first edge with reset == 1.
- Latency:
  - The last bit of a word is sampled at edge k; sr holds the word after k.
  - Output registers update at edge k+1.
  - Data-word latency is therefore WIDTH+1 clk_32f from its first bit.
- Lock:
  - active rises at the boundary edge that evaluates the LOCK_COMMAS-th comma.
  - That comma is not output.
- The first data word after lock appears WIDTH cycles later.
- valid changes only at boundary edges, except when it is forced to 0 on loss of lock or reset.
- Simultaneous events: a boundary edge and a misaligned-comma check cannot coincide. Reset has priority over everything.

## Structure
- Shared package `phy_pkg`:
  - default COMMA/IDLE constants (8'hBC, 8'h7C);
  - state encoding HUNT/CHECK/LOCKED.
- Sub-module `detector_coma`: the shift register plus the comparators against COMMA and IDLE, parametrised by WIDTH. It outputs sr, is_comma and is_idle.
- The top level holds the FSM, bit_cnt, comma_cnt, misalign_cnt and the output registers.

## Test plan
All scenarios use defaults (WIDTH=8, COMMA=BC, IDLE=7C, LOCK_COMMAS=4, MISALIGN_MAX=3).
- Reset: hold reset=0 for 10 cycles with random input -> all outputs 0; no lock for 32 cycles afterwards without commas.
- Arbitrary-offset lock:
  - Stimulus: 3 junk bits, then BC×4, A5, 3C.
  - Required: active=1 at the boundary edge that evaluates the 4th BC; data=A5 with valid=1; 8 cycles later data=3C; latency 9 cycles from the first bit.
- Incomplete lock:
  - Stimulus: BC×3, 55, then BC×4, 66.
  - Required: active stays 0 through 55; lock on the second BC run; data=66.
- Stripping (locked):
  - Stimulus: 11, 7C, BC, 22.
  - Required: data=11, valid=1; valid=0 for 16 cycles with data held at 11; then data=22, valid=1.
- Bit slip:
  - Stimulus: while locked, insert one extra bit, then BC on every word.
  - Required: on the 3rd misaligned BC, realign pulses for 1 cycle and active=valid=0, data=0; relock after 4 aligned BCs.
- Reset mid-operation:
  - Stimulus: reset=0 for 1 edge while valid=1.
  - Required: outputs 0 after that edge; full relock sequence required afterwards.
